// File: rtl/modem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modem_pkg                                                            |
// | Shared modem constants and types: ring geometry, header layout,      |
// | TX controller state encodings and message footprint helper.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package modem_pkg;

  localparam int HDR_LEN_MSB = 9;     // header bits [9:0] carry the byte count
  localparam int TX_MAX_LEN  = 1016;  // largest byte count accepted
  localparam int RING_AW     = 8;     // 256-word ring

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_HDR  = 6'b000010,
    S_WRD  = 6'b000100,
    S_LAT  = 6'b001000,
    S_PAY  = 6'b010000,
    S_DONE = 6'b100000
  } tx_state_t;

  // Ring words occupied by a message: header plus payload rounded up to words.
  function automatic logic [8:0] msg_words(input logic [HDR_LEN_MSB:0] n);
    logic [10:0] t;
    t = {1'b0, n} + 11'd3;
    return 9'd1 + t[10:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_ctrl_if                                                           |
// | Bus bundle between the TX controller, the ring RAM read port and     |
// | the modulator byte stream.                                           |
// |   raddr_o/ren_o/rdata_i : RAM read port (data one cycle after ren)   |
// |   byte_o/valid_o/ready_i/begin_o/end_o : framed byte stream          |
// | master = controller side, slave = RAM/sink side.                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface tx_ctrl_if;
  import modem_pkg::*;

  logic [RING_AW-1:0] raddr_o;
  logic               ren_o;
  logic [31:0]        rdata_i;
  logic [7:0]         byte_o;
  logic               valid_o;
  logic               ready_i;
  logic               begin_o;
  logic               end_o;

  modport master (
    output raddr_o, ren_o, byte_o, valid_o, begin_o, end_o,
    input  rdata_i, ready_i
  );

  modport slave (
    input  raddr_o, ren_o, byte_o, valid_o, begin_o, end_o,
    output rdata_i, ready_i
  );

endinterface
`default_nettype wire

// File: rtl/tx_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_byte_serializer                                                   |
// | Holds the current payload word and walks it out little-endian, one   |
// | byte per accepted transfer, framing the message with begin/end.      |
// |   i_start  : latch message length, clear byte index                  |
// |   i_load   : capture a payload word into the staging register        |
// |   i_active : controller is presenting payload (drives o_valid)       |
// |   o_word_done / o_msg_done : transfer of a word's / message's last   |
// |   byte in this cycle                                                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tx_byte_serializer
  import modem_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_start,
  input  wire logic [HDR_LEN_MSB:0] i_len,
  input  wire logic                 i_load,
  input  wire logic [31:0]          i_word,
  input  wire logic                 i_active,
  input  wire logic                 i_ready,
  output logic [7:0]                o_byte,
  output logic                      o_valid,
  output logic                      o_begin,
  output logic                      o_end,
  output logic                      o_word_done,
  output logic                      o_msg_done
);

  localparam logic [HDR_LEN_MSB:0] c_one = 1;

  logic [31:0]          r_stage;
  logic [HDR_LEN_MSB:0] r_bi;
  logic [HDR_LEN_MSB:0] r_len;

  logic w_xfer;
  logic w_last;

  assign w_xfer = i_active & i_ready;
  // Only evaluated while presenting payload, where r_len is at least 1.
  assign w_last = (r_bi == (r_len - c_one));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
      r_bi    <= '0;
      r_len   <= '0;
    end else begin
      if (i_start) begin
        r_len <= i_len;
        r_bi  <= '0;
      end
      if (i_load) begin
        r_stage <= i_word;
      end
      if (w_xfer) begin
        r_bi <= r_bi + c_one;
      end
    end
  end

  // Everything below depends only on registers, so a stalled byte holds.
  assign o_valid     = i_active;
  assign o_byte      = i_active ? r_stage[{r_bi[1:0], 3'b000} +: 8] : 8'h00;
  assign o_begin     = i_active & (r_bi == '0);
  assign o_end       = i_active & w_last;
  assign o_word_done = w_xfer & (r_bi[1:0] == 2'd3);
  assign o_msg_done  = w_xfer & w_last;

endmodule
`default_nettype wire

// File: rtl/tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_ctrl                                                              |
// | Transmit ring-buffer controller. Fetches header + payload messages   |
// | from the 256-word TX ring in [rp_o, wp_i), streams the payload as    |
// | framed bytes, then advances rp_o and pulses irq_o.                   |
// |   wp_i      : CPU write pointer                                      |
// |   rp_o      : read pointer (registered)                              |
// |   clk_req_o : clock request while busy or work is pending            |
// |   irq_o     : one-cycle pulse per consumed message                   |
// |   bus       : RAM read port and byte stream (tx_ctrl_if.master)      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tx_ctrl
  import modem_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [RING_AW-1:0] wp_i,
  output logic      [RING_AW-1:0] rp_o,
  output logic                    clk_req_o,
  output logic                    irq_o,
  tx_ctrl_if.master               bus
);

  tx_state_t          r_state;
  logic [RING_AW-1:0] r_rp;
  logic [RING_AW-1:0] r_wa;
  logic [RING_AW-1:0] r_next_rp;

  logic [HDR_LEN_MSB:0] w_len;
  logic [8:0]           w_words;
  logic [RING_AW-1:0]   w_avail;
  logic                 w_bad;
  logic                 w_pending;
  logic                 w_word_done;
  logic                 w_msg_done;

  assign w_len     = bus.rdata_i[HDR_LEN_MSB:0];
  assign w_words   = msg_words(w_len);
  assign w_avail   = wp_i - r_rp;
  assign w_pending = (wp_i != r_rp);
  // A message claiming more words than committed is treated as corrupt.
  assign w_bad     = (w_len > (HDR_LEN_MSB+1)'(TX_MAX_LEN)) || (w_words > {1'b0, w_avail});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rp      <= '0;
      r_wa      <= '0;
      r_next_rp <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pending) r_state <= S_HDR;
        end
        S_HDR: begin
          r_wa <= r_rp + RING_AW'(1);
          // Corrupt header: drop everything committed so far.
          r_next_rp <= w_bad ? wp_i : (r_rp + w_words[RING_AW-1:0]);
          if (w_bad || (w_len == '0)) r_state <= S_DONE;
          else                        r_state <= S_WRD;
        end
        S_WRD: begin
          r_state <= S_LAT;
        end
        S_LAT: begin
          r_wa    <= r_wa + RING_AW'(1);
          r_state <= S_PAY;
        end
        S_PAY: begin
          if (w_msg_done)       r_state <= S_DONE;
          else if (w_word_done) r_state <= S_WRD;
        end
        S_DONE: begin
          r_rp    <= r_next_rp;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tx_byte_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_start     (r_state == S_HDR),
    .i_len       (w_len),
    .i_load      (r_state == S_LAT),
    .i_word      (bus.rdata_i),
    .i_active    (r_state == S_PAY),
    .i_ready     (bus.ready_i),
    .o_byte      (bus.byte_o),
    .o_valid     (bus.valid_o),
    .o_begin     (bus.begin_o),
    .o_end       (bus.end_o),
    .o_word_done (w_word_done),
    .o_msg_done  (w_msg_done)
  );

  assign bus.ren_o   = ((r_state == S_IDLE) && w_pending) || (r_state == S_WRD);
  assign bus.raddr_o = (r_state == S_IDLE) ? r_rp : r_wa;
  assign rp_o        = r_rp;
  assign irq_o       = (r_state == S_DONE);
  assign clk_req_o   = (r_state != S_IDLE) || w_pending;

endmodule
`default_nettype wire

// File: tb/tb_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tx_ctrl                                                           |
// | Self-checking bench for tx_ctrl: directed messages are written into  |
// | a ring RAM model, expected bytes/pointers are queued, and monitors   |
// | pop and compare as the DUT presents them.                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wp_i = 8'd0;
  logic [7:0] rp_o;
  logic       clk_req_o;
  logic       irq_o;

  tx_ctrl_if bus ();

  tx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wp_i      (wp_i),
    .rp_o      (rp_o),
    .clk_req_o (clk_req_o),
    .irq_o     (irq_o),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (bus.ren_o) bus.rdata_i <= mem[bus.raddr_o];
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] q_byte [$];   // {byte, begin, end}
  logic [7:0] q_rp   [$];
  logic [7:0] q_addr [$];
  bit         addr_chk = 1'b0;

  logic [7:0] stall_byte = 8'h00;
  int         stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0h, required none", name, act);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, required completion", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Header n at base, payload byte k = start + step*k, little-endian.
  task automatic put_msg(input int base, input int n, input int start, input int step);
    mem[base & 255] = 32'(n);
    for (int w = 0; w < (n + 3) / 4; w++) mem[(base + 1 + w) & 255] = 32'h0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      int         a;
      b = 8'(start + step * k);
      a = (base + 1 + k / 4) & 255;
      mem[a][8*(k%4) +: 8] = b;
      q_byte.push_back({b, (k == 0), (k == n - 1)});
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while ((q_byte.size() != 0 || q_rp.size() != 0) && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) begin
      fail_timeout(name);
      q_byte.delete();
      q_rp.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Sink: ready high except for a programmed stall on a chosen byte.
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.valid_o && bus.byte_o == stall_byte) begin
        bus.ready_i = 1'b0;
        stall_left--;
      end else begin
        bus.ready_i = 1'b1;
      end
    end
  end

  // Byte stream and RAM address monitor.
  initial begin
    logic [9:0] e;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_o && bus.ready_i) begin
        if (q_byte.size() == 0) fail_unexpected("unexpected_byte", {bus.byte_o, bus.begin_o, bus.end_o});
        else begin
          e = q_byte.pop_front();
          check("byte_begin_end", {22'h0, bus.byte_o, bus.begin_o, bus.end_o}, {22'h0, e});
        end
      end
      if (addr_chk && bus.ren_o) begin
        if (q_addr.size() == 0) fail_unexpected("unexpected_raddr", bus.raddr_o);
        else begin
          a = q_addr.pop_front();
          check("raddr", bus.raddr_o, a);
        end
      end
    end
  end

  // Interrupt monitor: each pulse consumes one expected rp, seen next cycle.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && irq_o) begin
        if (q_rp.size() == 0) fail_unexpected("unexpected_irq", rp_o);
        else begin
          e = q_rp.pop_front();
          @(negedge clk);
          check("rp_after_irq", rp_o, e);
        end
      end
    end
  end

  initial begin
    int  k;
    bit  found;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rp", rp_o, 8'd0);
    check("reset_valid", bus.valid_o, 1'b0);
    check("reset_irq", irq_o, 1'b0);
    check("reset_ren", bus.ren_o, 1'b0);
    check("reset_raddr", bus.raddr_o, 8'd0);
    check("reset_byte", bus.byte_o, 8'd0);
    check("reset_begin_end", {bus.begin_o, bus.end_o}, 2'b00);
    check("reset_clk_req", clk_req_o, 1'b0);
    rst = 1'b0;

    // Basic 5-byte message at 0.
    put_msg(0, 5, 'h11, 'h11);
    q_rp.push_back(8'd3);
    tick();
    wp_i = 8'd3;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check("clk_req_on_commit", clk_req_o, 1'b1);
      if (bus.valid_o) begin
        k = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("first_valid");
    else check("first_valid_latency", k, 4);
    wait_done("basic");

    // Same message with a 3-cycle stall on byte 22.
    put_msg(3, 5, 'h11, 'h11);
    q_rp.push_back(8'd6);
    stall_byte = 8'h22;
    stall_left = 3;
    tick();
    wp_i = 8'd6;
    wait_done("backpressure");
    check("stall_applied", stall_left, 0);

    // Oversized header flushes up to wp (moves rp to 254).
    mem[6] = 32'd1017;
    q_rp.push_back(8'd254);
    tick();
    wp_i = 8'd254;
    wait_done("malformed_1017");

    // Wrap-around message 254..0.
    put_msg(254, 8, 1, 1);
    q_rp.push_back(8'd1);
    q_addr.push_back(8'd254);
    q_addr.push_back(8'd255);
    q_addr.push_back(8'd0);
    addr_chk = 1'b1;
    tick();
    wp_i = 8'd1;
    wait_done("wrap");
    addr_chk = 1'b0;
    check("raddr_all_seen", q_addr.size(), 0);

    // Header longer than committed words.
    mem[1] = 32'd20;
    q_rp.push_back(8'd4);
    tick();
    wp_i = 8'd4;
    wait_done("malformed_avail");

    // 20-byte multi-word message 4..9, upper header bits set and ignored.
    put_msg(4, 20, 'hA0, 1);
    mem[4] = 32'hFFFF_FC14;
    q_rp.push_back(8'd10);
    tick();
    wp_i = 8'd10;
    wait_done("twenty_bytes");

    // Zero-length message followed back-to-back by a 1-byte message.
    mem[10] = 32'd0;
    put_msg(11, 1, 'hC3, 0);
    q_rp.push_back(8'd11);
    q_rp.push_back(8'd13);
    tick();
    wp_i = 8'd13;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq_o) begin
        k = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("zero_len_irq");
    else check("zero_len_irq_latency", k, 2);
    wait_done("zero_then_one");

    // Reset while byte 22 of a 5-byte message is held.
    put_msg(13, 5, 'h11, 'h11);
    stall_byte = 8'h22;
    stall_left = 1000;
    tick();
    wp_i = 8'd16;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.valid_o && bus.byte_o == 8'h22) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("reach_byte_22");
    rst = 1'b1;
    @(negedge clk);
    q_byte.delete();
    stall_left = 0;
    check("rst_mid_valid", bus.valid_o, 1'b0);
    check("rst_mid_rp", rp_o, 8'd0);
    check("rst_mid_irq", irq_o, 1'b0);
    check("rst_mid_clk_req", clk_req_o, 1'b1);
    wp_i = 8'd0;
    @(negedge clk);
    check("rst_clk_req_idle", clk_req_o, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_rp", rp_o, 8'd0);
    check("no_pending_irq", q_rp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
